serial_cmp_seq: RTL

Bit-serial magnitude/equality comparator sequencer for the 4-bit comparator datapath. Accepts an operand pair through a valid/ready handshake, walks the bits MSB-first, one bit per clock, through a cascaded equality cell with an enable chain, and returns a registered eq/gt/lt result through a second valid/ready handshake. It sits upstream of the result consumer and replaces the fully combinational cascade when area matters more than latency.

---
 rtl/serial_cmp_seq_pkg.sv | 20 ++
 rtl/serial_cmp_seq_if.sv | 33 +++
 rtl/serial_cmp_seq_cmp_bit_cell.sv | 15 +
 rtl/serial_cmp_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/serial_cmp_seq_pkg.sv
// cmp_pkg: shared types and constants for the bit-serial comparator sequencer.
//   cmp_state_t       : sequencer states IDLE / RUN / DONE
//   CMP_EQ/GT/LT/OFF  : result codes packed as {eq, gt, lt}
//   CMP_DEFAULT_WIDTH : default operand width
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic [2:0] CMP_EQ  = 3'b100;
  localparam logic [2:0] CMP_GT  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b001;
  localparam logic [2:0] CMP_OFF = 3'b000;

  localparam int CMP_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_cmp_seq_if.sv
// serial_cmp_seq_if: operand/result handshake bundle of the serial comparator.
//   in_valid/in_ready/a/b/en : operand channel (master -> slave)
//   out_valid/out_ready      : result channel (slave -> master)
//   eq/gt/lt                 : result flags, valid while out_valid
//   busy                     : sequencer is walking bits
// Modports: master = producer/consumer side, slave = comparator side.
interface serial_cmp_seq_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, en, out_ready,
    input  in_ready, out_valid, eq, gt, lt, busy
  );

  modport slave (
    input  in_valid, a, b, en, out_ready,
    output in_ready, out_valid, eq, gt, lt, busy
  );
endinterface

// File: rtl/serial_cmp_seq_cmp_bit_cell.sv
// cmp_bit_cell: one stage of the cascaded equality comparator (combinational).
//   a_i, b_i : operand bits at the current position
//   e_i      : enable from the more significant stages (all equal so far)
//   eq_o     : enable passed on (bits equal and enabled)
//   mis_o    : this bit is the first mismatch seen while enabled
module cmp_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic e_i,
  output logic eq_o,
  output logic mis_o
);
  assign eq_o  = e_i & ~(a_i ^ b_i);
  assign mis_o = e_i &  (a_i ^ b_i);
endmodule

// File: rtl/serial_cmp_seq.sv
// serial_cmp_seq: bit-serial unsigned magnitude/equality comparator.
// Accepts {a, b, en} in IDLE, walks the bits MSB-first one per clock through
// a single cmp_bit_cell, then holds {eq, gt, lt} in DONE until taken.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_cmp_seq_if.slave (operand and result handshakes, busy)
// Build option: SERIAL_CMP_EARLY_EXIT_EN leaves RUN as soon as the outcome is
// settled (first mismatch, or en=0); results are identical either way.
module serial_cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_cmp_seq_if.slave    bus
);
  localparam int IDX_W = $clog2(WIDTH);

  cmp_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             chain_reg, chain_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;
  // Set once the last needed bit has been processed; RUN exits on the
  // following edge, which gives the DONE-entry cycle of the latency budget.
  logic             fin_reg, fin_next;

  logic a_bit, b_bit, cell_eq, cell_mis;

  assign a_bit = a_reg[idx_reg];
  assign b_bit = b_reg[idx_reg];

  cmp_bit_cell u_cell (
    .a_i   (a_bit),
    .b_i   (b_bit),
    .e_i   (chain_reg),
    .eq_o  (cell_eq),
    .mis_o (cell_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      chain_reg <= 1'b0;
      gt_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      fin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      idx_reg   <= idx_next;
      chain_reg <= chain_next;
      gt_reg    <= gt_next;
      lt_reg    <= lt_next;
      fin_reg   <= fin_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    idx_next   = idx_reg;
    chain_next = chain_reg;
    gt_next    = gt_reg;
    lt_next    = lt_reg;
    fin_next   = fin_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.b;
          chain_next = bus.en;
          idx_next   = IDX_W'(WIDTH - 1);
          gt_next    = 1'b0;
          lt_next    = 1'b0;
          fin_next   = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (fin_reg) begin
          state_next = DONE;
        end else begin
          chain_next = cell_eq;
          if (cell_mis) begin
            gt_next = a_bit;
            lt_next = b_bit;
          end
          // idx parks at 0 rather than wrapping.
          if (idx_reg == '0) fin_next = 1'b1;
          else               idx_next = idx_reg - 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (!chain_reg || cell_mis) fin_next = 1'b1;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Everything below decodes registered state only.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg == RUN);
  assign bus.out_valid = (state_reg == DONE);
  assign {bus.eq, bus.gt, bus.lt} = (state_reg == DONE) ? {chain_reg, gt_reg, lt_reg}
                                                        : CMP_OFF;
endmodule
